// File: rtl/l1_dcache_dm_if.sv
// Core-side and memory-side bus bundle for the direct-mapped L1 data cache.
// Core side: word request (address/read/write/byte_enable/wdata) and read data with a resp pulse.
// Memory side: line address, read/write strobes held until resp, 256-bit line data in both directions.
interface l1_dcache_dm_if;
  // core side
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  // physical memory side
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  // cache view
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // core + memory view
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_dcache_dm.sv
// Direct-mapped write-back write-allocate L1 data cache, 32-byte lines.
// Ports: clk, rst (async active-high), bus (l1_dcache_dm_if.slave: core word port + line memory port).
// Hit completes the cycle after the request is seen; misses write back a dirty victim, then fill.
module l1_dcache_dm #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic clk,
  input  logic rst,
  l1_dcache_dm_if.slave bus
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_W   = 256;
  localparam int WSEL_W   = S_OFFSET - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [LINE_W-1:0]   data_arr [NUM_SETS];

  logic [S_INDEX-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [WSEL_W-1:0]   wsel;
  logic [WSEL_W+4:0]   wbase;
  logic [LINE_W-1:0]   line;
  logic [31:0]         cur_word;
  logic [31:0]         merged_word;
  logic                hit;
  logic                fill_en;
  logic                wr_hit;
  logic                unused_ok;

  // The core holds its request stable, so all decode works straight off the live address.
  assign idx      = bus.mem_address[S_OFFSET +: S_INDEX];
  assign tag      = bus.mem_address[31 -: TAG_W];
  assign wsel     = bus.mem_address[S_OFFSET-1:2];
  assign wbase    = {wsel, 5'b0};
  assign line     = data_arr[idx];
  assign cur_word = line[wbase +: 32];
  assign hit      = valid[idx] && (tag_arr[idx] == tag);

  // Byte offset is irrelevant: byte lanes arrive already positioned.
  assign unused_ok = ^bus.mem_address[1:0];

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
    end
  end

  assign bus.mem_rdata  = cur_word;
  // Only meaningful in WRITEBACK, where the indexed line is the victim.
  assign bus.pmem_wdata = line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 32'h0;
    fill_en          = 1'b0;
    wr_hit           = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          // read+write together is handled as a write
          wr_hit       = bus.mem_write;
          state_nxt    = IDLE;
        end else if (valid[idx] && dirty[idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        if (bus.pmem_resp) begin
          fill_en   = 1'b1;
          // re-enter COMPARE so the filled line completes the request as a hit
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_hit) begin
      // set even with no byte lanes enabled
      dirty[idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_arr[idx] <= bus.pmem_rdata;
      tag_arr[idx]  <= tag;
    end else if (wr_hit) begin
      data_arr[idx][wbase +: 32] <= merged_word;
    end
  end

endmodule

// File: tb/tb_l1_dcache_dm.sv
module tb_l1_dcache_dm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_dcache_dm_if bus();

  l1_dcache_dm #(.S_INDEX(3), .S_OFFSET(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_read;
    bit          hit;
    logic [31:0] rdata;
    int          issue;
    string       name;
  } sexp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } pexp_t;

  sexp_t sq[$];
  pexp_t pq[$];

  // Reference: a flat line-granular memory image as the core should see it,
  // plus the tag/valid/dirty state the placement rules imply per set.
  logic [255:0] ref_line [int unsigned];
  logic [255:0] backing  [int unsigned];
  bit           m_valid  [8];
  bit           m_dirty  [8];
  int unsigned  m_line   [8];
  bit           pm_hold = 1'b0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(int unsigned la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = (la * 32'h0100_0193) ^ (w * 32'h1111_1111) ^ 32'h5A5A_1234;
    return l;
  endfunction

  function automatic logic [255:0] get_ref(int unsigned la);
    if (ref_line.exists(la)) return ref_line[la];
    return init_line(la);
  endfunction

  function automatic logic [255:0] get_bk(int unsigned la);
    if (backing.exists(la)) return backing[la];
    return init_line(la);
  endfunction

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Memory responder: checks each line operation against the expected queue, then answers.
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.pmem_read && bus.pmem_write) chk("pmem_rd_wr_both", 1'b1, 1'b0);
      if (bus.pmem_read || bus.pmem_write) begin
        pexp_t       e;
        logic [31:0] a;
        bit          wr;
        bit          abort;
        int          d;
        wr = bus.pmem_write;
        a  = bus.pmem_address;
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pmem_unexpected actual wr=%0d addr=%0h required none", wr, a);
        end else begin
          e = pq.pop_front();
          chk("pmem_kind", wr, e.wr);
          chk("pmem_addr", a, e.addr);
          if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.data);
        end
        d = (pm_hold && !wr) ? 2000 : $urandom_range(0, 3);
        abort = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (rst || !(bus.pmem_read || bus.pmem_write)) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          if (wr) backing[a >> 5] = bus.pmem_wdata;
          else    bus.pmem_rdata  = get_bk(a >> 5);
          bus.pmem_resp = 1'b1;
          @(negedge clk);
          bus.pmem_resp = 1'b0;
        end
      end
    end
  end

  // Core-side monitor: every resp pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.mem_resp) begin
      if (sq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_resp_unexpected actual=1 required=0 cycle=%0d", cyc);
      end else begin
        sexp_t e;
        e = sq.pop_front();
        if (e.is_read) chk({e.name, "_rdata"}, bus.mem_rdata, e.rdata);
        if (e.hit) chk({e.name, "_hit_latency"}, cyc - e.issue, 1);
        else       chk({e.name, "_miss_latency_ge3"}, (cyc - e.issue) >= 3, 1'b1);
        chk({e.name, "_pmem_pending"}, pq.size(), 0);
      end
    end
  end

  task automatic do_req(string name, logic [31:0] addr, bit rd, bit wr,
                        logic [3:0] be, logic [31:0] wd);
    int unsigned  la;
    int           idx;
    int           wo;
    bit           hit;
    logic [255:0] l;
    sexp_t        e;
    la  = addr >> 5;
    idx = la % 8;
    wo  = addr[4:2];
    hit = m_valid[idx] && (m_line[idx] == la);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        pq.push_back('{wr: 1'b1, addr: m_line[idx] << 5, data: get_ref(m_line[idx])});
      pq.push_back('{wr: 1'b0, addr: la << 5, data: '0});
      m_valid[idx] = 1'b1;
      m_line[idx]  = la;
      m_dirty[idx] = 1'b0;
    end
    l = get_ref(la);
    e.is_read = rd && !wr;
    e.hit     = hit;
    e.rdata   = l[wo*32 +: 32];
    e.issue   = cyc;
    e.name    = name;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) l[wo*32 + b*8 +: 8] = wd[b*8 +: 8];
      ref_line[la] = l;
      m_dirty[idx] = 1'b1;
    end
    sq.push_back(e);
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.mem_resp) break;
    end
    if (!bus.mem_resp) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no mem_resp required=mem_resp", name);
      finish_now();
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Read miss that is cut off by reset while the line fill is outstanding.
  task automatic reset_mid_alloc(logic [31:0] addr);
    int unsigned la;
    int          idx;
    bit          seen;
    la  = addr >> 5;
    idx = la % 8;
    pm_hold = 1'b1;
    if (!(m_valid[idx] && m_line[idx] == la)) begin
      if (m_valid[idx] && m_dirty[idx])
        pq.push_back('{wr: 1'b1, addr: m_line[idx] << 5, data: get_ref(m_line[idx])});
      pq.push_back('{wr: 1'b0, addr: la << 5, data: '0});
    end
    m_valid[idx] = 1'b0;
    m_dirty[idx] = 1'b0;
    bus.mem_address = addr;
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_alloc_reached", seen, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_mid_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_mid_pmem_address", bus.pmem_address, 32'h0);
    chk("rst_mid_mem_resp", bus.mem_resp, 1'b0);
    bus.mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    pm_hold = 1'b0;
    // dirty lines held only in the cache are lost
    for (int s = 0; s < 8; s++) begin
      if (m_valid[s] && m_dirty[s]) ref_line[m_line[s]] = get_bk(m_line[s]);
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [26:0] tagv;
    logic [31:0] a;
    bit          rd;
    bit          wr;
    rst = 1'b1;
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_line[s]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_resp", bus.mem_resp, 1'b0);
    chk("reset_pmem_read", bus.pmem_read, 1'b0);
    chk("reset_pmem_write", bus.pmem_write, 1'b0);
    chk("reset_pmem_address", bus.pmem_address, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    do_req("t1_cold_rd",    32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    do_req("t2_hit_rd",     32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    do_req("t3_wr_byte2",   32'h0000_0104, 0, 1, 4'b0100, 32'h00AB_0000);
    do_req("t3_rd_merged",  32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    do_req("t4_evict_rd",   32'h0000_1104, 1, 0, 4'b0000, 32'h0);
    do_req("t6_rdwr_hit",   32'h0000_1108, 1, 1, 4'b1111, 32'hDEAD_BEEF);
    do_req("t6_rd_back",    32'h0000_1108, 1, 0, 4'b0000, 32'h0);
    do_req("be0_wr",        32'h0000_1110, 0, 1, 4'b0000, 32'h1234_5678);
    do_req("be0_evict_rd",  32'h0000_2110, 1, 0, 4'b0000, 32'h0);
    do_req("set1_wr",       32'h0000_0124, 0, 1, 4'b0011, 32'h0000_C0DE);
    reset_mid_alloc(32'h0000_3104);
    do_req("t5_reread",     32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    do_req("t5_dropped_rd", 32'h0000_0124, 1, 0, 4'b0000, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       tagv = 27'h0;
        1:       tagv = 27'h1;
        2:       tagv = 27'h12345;
        default: tagv = 27'h7FF_FFFF;
      endcase
      a  = {tagv, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      rd = ($urandom_range(0, 2) != 0);
      wr = !rd || ($urandom_range(0, 7) == 0);
      do_req("rnd", a, rd, wr, 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("end_resp_queue_empty", sq.size(), 0);
    chk("end_pmem_queue_empty", pq.size(), 0);
    finish_now();
  end

endmodule
